// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/HOLD/HALT sequencer with branch, jump and JR redirect.
// Optional macro IFETCH_ALIGN_CHECK_EN halts on a misaligned next PC instead of masking it.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    input  logic        dobranch,
    input  logic        dojump,
    input  logic        dojumpreg,
    input  logic [31:0] jr_target,
    output logic        fetch_err
);

    localparam logic [1:0] S_FETCH = 2'b00;
    localparam logic [1:0] S_HOLD  = 2'b01;
    localparam logic [1:0] S_HALT  = 2'b10;

    logic [1:0]  state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] branch_off;
    logic [31:0] jump_target;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        retire;
    logic        misaligned;

    // pc_q is both the outstanding fetch address and the address of the held instruction
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pcplus4     = pc_q + 32'd4;
    assign instr       = instr_q;
    assign imem_req    = (state == S_FETCH);
    assign instr_valid = (state == S_HOLD);
    assign retire      = (state == S_HOLD) && instr_ready;

    assign branch_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jump_target = {pcplus4[31:28], instr_q[25:0], 2'b00};

    always_comb begin
        target = pcplus4;
        if (dojumpreg) begin
            target = jr_target;
        end else if (dojump) begin
            target = jump_target;
        end else if (dobranch) begin
            target = pcplus4 + branch_off;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    logic err_q;

    assign misaligned = |target[1:0];
    assign next_pc    = target;
    assign fetch_err  = err_q;

    // The error flag is sticky until reset, matching the HALT state it accompanies
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (retire && misaligned) begin
            err_q <= 1'b1;
        end
    end
`else
    assign misaligned = 1'b0;
    assign next_pc    = target & 32'hFFFF_FFFC;
    assign fetch_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (retire) begin
                        if (misaligned) begin
                            state <= S_HALT;
                        end else begin
                            pc_q  <= next_pc;
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: chained redirect vectors plus stall, misalignment and reset corner cases.
// Follows IFETCH_ALIGN_CHECK_EN to pick the expected misaligned-JR behaviour.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h00400000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        dobranch;
    logic        dojump;
    logic        dojumpreg;
    logic [31:0] jr_target;
    logic        fetch_err;

    int total;
    int bad;

    typedef struct {
        logic [31:0] rdata;
        int          waits;
        logic        br;
        logic        j;
        logic        jr;
        logic [31:0] jrt;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs [17];

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .dobranch    (dobranch),
        .dojump      (dojump),
        .dojumpreg   (dojumpreg),
        .jr_target   (jr_target),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        dobranch    = 1'b0;
        dojump      = 1'b0;
        dojumpreg   = 1'b0;
        jr_target   = 32'h0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".imem_req"},    {31'h0, imem_req},    32'h1);
        checkOutput({tag, ".imem_addr"},   imem_addr,            RESET_PC);
        checkOutput({tag, ".instr_valid"}, {31'h0, instr_valid}, 32'h0);
        checkOutput({tag, ".pc"},          pc,                   RESET_PC);
        checkOutput({tag, ".pcplus4"},     pcplus4,              RESET_PC + 32'd4);
        checkOutput({tag, ".instr"},       instr,                32'h0);
        checkOutput({tag, ".fetch_err"},   {31'h0, fetch_err},   32'h0);
    endtask

    // Called in FETCH; leaves the DUT in HOLD with the word captured
    task automatic fetchWord(input string tag, input logic [31:0] rdata, input int waits,
                             input logic [31:0] exp_pc);
        for (int w = 0; w < waits; w++) begin
            checkOutput({tag, ".wait_req"},  {31'h0, imem_req}, 32'h1);
            checkOutput({tag, ".wait_addr"}, imem_addr,         exp_pc);
            nextCycle();
        end
        checkOutput({tag, ".ack_addr"}, imem_addr, exp_pc);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        nextCycle();
        imem_ack   = 1'b0;
        imem_rdata = 32'hA5A5_5A5A;
        checkOutput({tag, ".valid"},   {31'h0, instr_valid}, 32'h1);
        checkOutput({tag, ".req_off"}, {31'h0, imem_req},    32'h0);
        checkOutput({tag, ".instr"},   instr,                rdata);
        checkOutput({tag, ".pc"},      pc,                   exp_pc);
        checkOutput({tag, ".pcplus4"}, pcplus4,              exp_pc + 32'd4);
    endtask

    task automatic retireInstr(input string tag, input logic br, input logic j, input logic jr,
                               input logic [31:0] jrt, input logic [31:0] exp_next);
        dobranch    = br;
        dojump      = j;
        dojumpreg   = jr;
        jr_target   = jrt;
        instr_ready = 1'b1;
        nextCycle();
        clearInputs();
        checkOutput({tag, ".next_req"},   {31'h0, imem_req},    32'h1);
        checkOutput({tag, ".next_valid"}, {31'h0, instr_valid}, 32'h0);
        checkOutput({tag, ".next_addr"},  imem_addr,            exp_next);
        checkOutput({tag, ".fetch_err"},  {31'h0, fetch_err},   32'h0);
    endtask

    task automatic applyStimulus(input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        fetchWord(tag, vecs[idx].rdata, vecs[idx].waits, vecs[idx].exp_pc);
        retireInstr(tag, vecs[idx].br, vecs[idx].j, vecs[idx].jr, vecs[idx].jrt, vecs[idx].exp_next);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // {rdata, waits, br, j, jr, jr_target, pc of instr, next fetch address}
        vecs[0]  = '{32'h24080005, 2, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400000, 32'h00400004};
        vecs[1]  = '{32'h00000000, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400004, 32'h00400008};
        vecs[2]  = '{32'h1000FFFF, 1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00400008, 32'h00400008};
        vecs[3]  = '{32'h08100004, 0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h00400008, 32'h00400010};
        vecs[4]  = '{32'h10000003, 3, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00400010, 32'h00400020};
        vecs[5]  = '{32'h08100000, 0, 1'b1, 1'b1, 1'b1, 32'h00400040, 32'h00400020, 32'h00400040};
        vecs[6]  = '{32'h10000005, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400040, 32'h00400044};
        vecs[7]  = '{32'h1000FFF0, 1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00400044, 32'h00400008};
        vecs[8]  = '{32'h00000000, 0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h00400008, 32'hFFFFFFFC};
        vecs[9]  = '{32'h00000000, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFC, 32'h00000000};
        vecs[10] = '{32'h1000FFFE, 0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00000000, 32'hFFFFFFFC};
        vecs[11] = '{32'h0BFFFFFF, 0, 1'b0, 1'b1, 1'b0, 32'h0,        32'hFFFFFFFC, 32'h0FFFFFFC};
        vecs[12] = '{32'h00000000, 0, 1'b0, 1'b0, 1'b1, 32'h90000000, 32'h0FFFFFFC, 32'h90000000};
        vecs[13] = '{32'h08000010, 0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h90000000, 32'h90000040};
        vecs[14] = '{32'h00000000, 0, 1'b0, 1'b0, 1'b1, 32'h9FFFFFFC, 32'h90000040, 32'h9FFFFFFC};
        vecs[15] = '{32'h08000001, 0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h9FFFFFFC, 32'hA0000004};
        vecs[16] = '{32'h00000000, 0, 1'b0, 1'b0, 1'b1, 32'h00400000, 32'hA0000004, 32'h00400000};

        clearInputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkResetState("reset");

        for (int i = 0; i < 17; i++) begin
            applyStimulus(i);
        end

        // Redirects and instr_ready while fetching must not disturb the request
        $display("[TB] stall and ignored-input sequence");
        instr_ready = 1'b1;
        dojumpreg   = 1'b1;
        jr_target   = 32'h00400100;
        for (int c = 0; c < 2; c++) begin
            nextCycle();
            checkOutput("fetch_ignore.addr", imem_addr, RESET_PC);
            checkOutput("fetch_ignore.req",  {31'h0, imem_req}, 32'h1);
        end
        clearInputs();
        fetchWord("stall", 32'h24080005, 0, RESET_PC);
        for (int c = 0; c < 5; c++) begin
            dobranch   = 1'b1;
            imem_ack   = 1'b1;
            imem_rdata = 32'hFFFFFFFF;
            nextCycle();
            checkOutput("stall.valid", {31'h0, instr_valid}, 32'h1);
            checkOutput("stall.req",   {31'h0, imem_req},    32'h0);
            checkOutput("stall.instr", instr,                32'h24080005);
            checkOutput("stall.pc",    pc,                   RESET_PC);
        end
        clearInputs();
        retireInstr("stall_jr", 1'b0, 1'b0, 1'b1, 32'h00400020, 32'h00400020);

        $display("[TB] misaligned register jump");
        fetchWord("misalign", 32'h00000000, 0, 32'h00400020);
        dojumpreg   = 1'b1;
        jr_target   = 32'h00400022;
        instr_ready = 1'b1;
        nextCycle();
        clearInputs();
`ifdef IFETCH_ALIGN_CHECK_EN
        for (int c = 0; c < 4; c++) begin
            checkOutput("halt.fetch_err", {31'h0, fetch_err},   32'h1);
            checkOutput("halt.req",       {31'h0, imem_req},    32'h0);
            checkOutput("halt.valid",     {31'h0, instr_valid}, 32'h0);
            imem_ack    = 1'b1;
            instr_ready = 1'b1;
            nextCycle();
        end
        clearInputs();
        checkOutput("halt_end.fetch_err", {31'h0, fetch_err}, 32'h1);
        checkOutput("halt_end.req",       {31'h0, imem_req},  32'h0);
`else
        checkOutput("misalign.req",       {31'h0, imem_req},  32'h1);
        checkOutput("misalign.addr",      imem_addr,          32'h00400020);
        checkOutput("misalign.fetch_err", {31'h0, fetch_err}, 32'h0);
`endif
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkResetState("reset_after_misalign");

        $display("[TB] reset with simultaneous ack");
        fetchWord("pre_rst", 32'h24080005, 0, RESET_PC);
        retireInstr("pre_rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h00400004);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        nextCycle();
        reset = 1'b0;
        clearInputs();
        checkResetState("rst_ack");
        nextCycle();
        checkOutput("rst_ack_after.valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("rst_ack_after.req",   {31'h0, imem_req},    32'h1);
        checkOutput("rst_ack_after.instr", instr,                32'h0);

        $display("[TB] reset while holding");
        fetchWord("hold_rst", 32'h8C000000, 1, RESET_PC);
        reset       = 1'b1;
        instr_ready = 1'b1;
        dojumpreg   = 1'b1;
        jr_target   = 32'h00400080;
        nextCycle();
        reset = 1'b0;
        clearInputs();
        checkResetState("rst_hold");
        nextCycle();
        checkOutput("rst_hold_after.addr",  imem_addr,            RESET_PC);
        checkOutput("rst_hold_after.valid", {31'h0, instr_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
